masked_store_unit: RTL
======================

# masked_store_unit

Read-modify-write engine performing a masked store: writes only the bits of a memory word selected by a mask and preserves the rest. It is the write-side counterpart of the CPU's mask filter, which extracts `in & mask` on loads. It sits between the load/store stage and the memory bus. The bus word is replaced by `(old & ~mask) | (data & mask)`.

## Interface
- `ADDR_WIDTH`, default 16: memory address width.
- `DATA_WIDTH`, default 32: data word and mask width.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  store request present.
- `req_ready`  out  1  unit can accept a request; high only in IDLE.
- `req_addr`  in  ADDR_WIDTH  target address.
- `req_data`  in  DATA_WIDTH  data to store.
- `req_mask`  in  DATA_WIDTH  1 = take bit from `req_data`, 0 = keep memory bit.
- `done`  out  1  one-cycle pulse when the store completes.
- `mem_addr`  out  ADDR_WIDTH  bus address.
- `mem_rd`  out  1  read strobe, held until ack.
- `mem_wr`  out  1  write strobe, held until ack.
- `mem_wdata`  out  DATA_WIDTH  write data.
- `mem_rdata`  in  DATA_WIDTH  read data, valid in the cycle where `mem_ack` is high during READ.
- `mem_ack`  in  1  bus completion, any number of wait cycles.

## Operation
- Request accepted when `req_valid && req_ready` at a clock edge.
  - On acceptance, `req_addr`, `req_data` and `req_mask` are latched.
  - Inputs are don't-care afterwards.
- States: IDLE, READ, WRITE, DONE.
- IDLE, on acceptance:
  - mask == 0 goes to DONE; no bus access.
  - mask == all ones goes to WRITE with `mem_wdata = data`; no read.
  - Otherwise goes to READ.
- READ:
  - `mem_rd=1`, `mem_addr=` latched address.
  - On `mem_ack`, register `merged = (mem_rdata & ~mask) | (data & mask)` and go to WRITE.
- WRITE:
  - `mem_wr=1`, `mem_addr=` latched address, `mem_wdata=merged`.
  - On `mem_ack`, go to DONE.
- DONE: `done=1` for exactly one cycle, then IDLE.
- `mem_ack` is ignored in IDLE and DONE.
- All outputs are decoded from registered state and registers only; no combinational path from inputs to outputs.
- `mem_rd` and `mem_wr` are never high in the same cycle.
- `mem_addr` and `mem_wdata` hold stable for the whole strobe.

## Timing
- Reset values:
  - state IDLE.
  - `req_ready=1`.
  - `done=0`, `mem_rd=0`, `mem_wr=0`.
  - `mem_addr=0`, `mem_wdata=0`; latched registers 0.
- Reset mid-operation: the cycle after the `rst` edge, state is IDLE and strobes are low. The in-flight store is abandoned and no `done` is issued. Reset wins over a simultaneous `mem_ack` or `req_valid`.
- Latency, counted from the acceptance edge E, with 0-wait bus (ack in the first strobe cycle):
  - Partial mask: READ in E+1, WRITE in E+2, `done` in E+3, `req_ready` high again in E+4.
  - Full mask: WRITE in E+1, `done` in E+2.
  - Zero mask: `done` in E+1.
- Each bus wait cycle adds one cycle.
- `req_ready` is low from E+1 until the DONE cycle completes. Back-to-back requests are spaced by at least one IDLE cycle.
- `mem_rdata` is sampled only on the READ-state `mem_ack` edge.

## Test plan
- Reset: hold `rst` 2 cycles with `req_valid=1` -> `req_ready=1`, `done=0`, `mem_rd=0`, `mem_wr=0`, no acceptance.
- Partial merge, zero-wait bus: addr 0x0010, data 0x12312312, mask 0xf0f0f0f0, memory returns 0xffffffff.
  - Expected: read then write to 0x0010 with `mem_wdata=0x1f3f2f1f`.
  - `done` pulses at E+3.
- Wait states: mask 0x50f37431, data 0xffffffff, memory 0x00000000; `mem_ack` delayed 3 cycles on read and 2 on write.
  - Expected: `mem_wdata=0x50f37431`.
  - Strobes and address are stable while waiting; `done` at E+8.
- Full mask 0xffffffff, data 0xdeadbeef -> no `mem_rd`; write 0xdeadbeef at E+1; `done` at E+2.
- Zero mask -> no strobes at all; `done` at E+1; `req_ready` back at E+2.
- Reset asserted in WRITE while `mem_ack=1` -> next cycle IDLE, `mem_wr=0`, no `done`.
  - A following partial request completes normally.
  - Also check: `mem_ack` pulses in IDLE have no effect.

Source files
------------

// File: rtl/masked_store_unit.sv
// rtl/masked_store_unit.sv - read-modify-write engine for bit-masked memory stores
module masked_store_unit #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic [DATA_WIDTH-1:0] req_mask,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    state_t                r_state;
    logic                  r_req_ready;
    logic                  r_done;
    logic                  r_mem_rd;
    logic                  r_mem_wr;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_mask;

    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_merged;

    assign w_accept = req_valid && r_req_ready && (r_state == S_IDLE);
    assign w_merged = (mem_rdata & ~r_mask) | (r_data & r_mask);

    // r_mem_addr doubles as the latched request address for the whole operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_done      <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_data      <= '0;
            r_mask      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_mem_addr  <= req_addr;
                        r_data      <= req_data;
                        r_mask      <= req_mask;
                        if (~|req_mask) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else if (&req_mask) begin
                            // Full overwrite: the old word is irrelevant, skip the read.
                            r_state     <= S_WRITE;
                            r_mem_wr    <= 1'b1;
                            r_mem_wdata <= req_data;
                        end else begin
                            r_state  <= S_READ;
                            r_mem_rd <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (mem_ack) begin
                        r_state     <= S_WRITE;
                        r_mem_rd    <= 1'b0;
                        r_mem_wr    <= 1'b1;
                        r_mem_wdata <= w_merged;
                    end
                end
                S_WRITE: begin
                    if (mem_ack) begin
                        r_state  <= S_DONE;
                        r_mem_wr <= 1'b0;
                        r_done   <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_done      <= 1'b0;
                    r_req_ready <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign done      = r_done;
    assign mem_addr  = r_mem_addr;
    assign mem_rd    = r_mem_rd;
    assign mem_wr    = r_mem_wr;
    assign mem_wdata = r_mem_wdata;
endmodule
